// File: rtl/zion_oh2bin_pipe.sv
// zion_oh2bin_pipe
//   Multi-channel pipelined onehot-to-binary encoder with one valid/ready handshake shared by all lanes.
//   Lane c maps its lowest set bit index k to (START + k*STEP) truncated to WIDTH_OUT bits.
//   PIPE=1: full encode in one stage. PIPE=2: per-group hit/local index first, then group select + scale.
//   Optional feature macro: ZION_OH2BIN_ERRCHK_EN adds oErr (lane not exactly-onehot) and oErrStk.
module zion_oh2bin_pipe #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 3,
  parameter int CHN       = 1,
  parameter int START     = 0,
  parameter int STEP      = 1,
  parameter int PIPE      = 1,
  parameter int GRP       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     iVld,
  output logic                     iRdy,
  input  logic [CHN*WIDTH_IN-1:0]  iDat,
  output logic                     oVld,
  input  logic                     oRdy,
  output logic [CHN*WIDTH_OUT-1:0] oDat,
  output logic [CHN-1:0]           oHit
`ifdef ZION_OH2BIN_ERRCHK_EN
  ,
  output logic [CHN-1:0]           oErr,
  output logic                     oErrStk
`endif
);

  // Configuration sanity checks, evaluated at elaboration.
  if (PIPE != 1 && PIPE != 2) begin : g_chk_pipe
    $error("zion_oh2bin_pipe: PIPE must be 1 or 2 (got %0d)", PIPE);
  end
  if (PIPE == 2 && (WIDTH_IN % GRP) != 0) begin : g_chk_grp
    $error("zion_oh2bin_pipe: GRP (%0d) must divide WIDTH_IN (%0d)", GRP, WIDTH_IN);
  end
  if ((longint'(START) + longint'(WIDTH_IN - 1) * longint'(STEP)) >
      ((longint'(1) << WIDTH_OUT) - 1)) begin : g_chk_trunc
    $warning("zion_oh2bin_pipe: encoded range exceeds WIDTH_OUT=%0d bits, results truncate", WIDTH_OUT);
  end

  // Lowest set bit index of a full lane (0 when the lane is empty).
  function automatic logic [31:0] low_idx(input logic [WIDTH_IN-1:0] x);
    logic [31:0] k;
    k = '0;
    for (int i = WIDTH_IN - 1; i >= 0; i--) begin
      if (x[i]) k = 32'(i);
    end
    return k;
  endfunction

  // Index to output value: 32-bit arithmetic, then plain truncation (no saturation).
  function automatic logic [WIDTH_OUT-1:0] enc_val(input logic [31:0] k);
    logic [31:0] v;
    v = 32'(START) + k * 32'(STEP);
    return v[WIDTH_OUT-1:0];
  endfunction

  logic                     vld0;
  logic                     adv0;
  logic                     ld0;
  logic                     ld_last;
  logic                     vld_out;
  logic [CHN*WIDTH_OUT-1:0] nxt_dat;
  logic [CHN-1:0]           nxt_hit;
  logic [CHN*WIDTH_OUT-1:0] out_dat;
  logic [CHN-1:0]           out_hit;

  // Stage 0 can take a beat when empty or when its beat moves on this cycle; oRdy ripples through here.
  assign iRdy = ~vld0 | adv0;
  assign ld0  = iVld & iRdy;

  assign oVld = vld_out;
  assign oDat = out_dat;
  assign oHit = out_hit;

  // Stage 0 occupancy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n)    vld0 <= 1'b0;
    else if (ld0)  vld0 <= 1'b1;
    else if (adv0) vld0 <= 1'b0;
  end

  if (PIPE == 1) begin : g_p1
    assign adv0    = vld0 & oRdy;
    assign ld_last = ld0;
    assign vld_out = vld0;

    // Full per-lane encode straight from the input beat.
    always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      nxt_dat = '0;
      nxt_hit = '0;
      for (int c = 0; c < CHN; c++) begin
        nxt_hit[c] = |iDat[c*WIDTH_IN +: WIDTH_IN];
        if (nxt_hit[c]) nxt_dat[c*WIDTH_OUT +: WIDTH_OUT] = enc_val(low_idx(iDat[c*WIDTH_IN +: WIDTH_IN]));
      end
    end
  end else begin : g_p2
    localparam int NGRP = WIDTH_IN / GRP;
    localparam int LW   = (GRP > 1) ? $clog2(GRP) : 1;

    // Lowest set bit index inside one group.
    function automatic logic [LW-1:0] low_local(input logic [GRP-1:0] x);
      logic [LW-1:0] k;
      k = '0;
      for (int i = GRP - 1; i >= 0; i--) begin
        if (x[i]) k = LW'(i);
      end
      return k;
    endfunction

    logic                             vld1;
    logic                             adv1;
    logic [CHN-1:0][NGRP-1:0]         ghit_d;
    logic [CHN-1:0][NGRP-1:0]         ghit_q;
    logic [CHN-1:0][NGRP-1:0][LW-1:0] gidx_d;
    logic [CHN-1:0][NGRP-1:0][LW-1:0] gidx_q;
    logic [31:0]                      k;

    assign adv1    = vld1 & oRdy;
    assign ld_last = vld0 & (~vld1 | adv1);
    assign adv0    = ld_last;
    assign vld_out = vld1;

    // First half of the tree: per-group hit flag and local index.
    always_comb begin
      ghit_d = '0;
      gidx_d = '0;
      for (int c = 0; c < CHN; c++) begin
        for (int g = 0; g < NGRP; g++) begin
          ghit_d[c][g] = |iDat[c*WIDTH_IN + g*GRP +: GRP];
          gidx_d[c][g] = low_local(iDat[c*WIDTH_IN + g*GRP +: GRP]);
        end
      end
    end

    // Stage 0 group payload.
    always_ff @(posedge clk) begin
      // NOTE: payload-only flops have no reset; vld0 already masks whatever they hold.
      if (ld0) begin
        ghit_q <= ghit_d;
        gidx_q <= gidx_d;
      end
    end

    // Stage 1 occupancy flag.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       vld1 <= 1'b0;
      else if (ld_last) vld1 <= 1'b1;
      else if (adv1)    vld1 <= 1'b0;
    end

    // Second half: pick the lowest hit group and form the scaled value.
    always_comb begin
      nxt_dat = '0;
      nxt_hit = '0;
      k       = '0;
      for (int c = 0; c < CHN; c++) begin
        k = '0;
        for (int g = NGRP - 1; g >= 0; g--) begin
          if (ghit_q[c][g]) k = 32'(g * GRP) + 32'(gidx_q[c][g]);
        end
        nxt_hit[c] = |ghit_q[c];
        if (nxt_hit[c]) nxt_dat[c*WIDTH_OUT +: WIDTH_OUT] = enc_val(k);
      end
    end
  end

  // Output stage payload; reset so idle outputs read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_dat <= '0;
      out_hit <= '0;
    end else if (ld_last) begin
      out_dat <= nxt_dat;
      out_hit <= nxt_hit;
    end
  end

`ifdef ZION_OH2BIN_ERRCHK_EN
  // Zero or more than one bit set.
  function automatic logic not_onehot(input logic [WIDTH_IN-1:0] x);
    return (x == '0) || ((x & (x - WIDTH_IN'(1))) != '0);
  endfunction

  logic [CHN-1:0] err_d;
  logic [CHN-1:0] nxt_err;
  logic [CHN-1:0] out_err;
  logic           err_stk;

  // Per-lane onehot violation detect on the incoming beat.
  always_comb begin
    err_d = '0;
    for (int c = 0; c < CHN; c++) err_d[c] = not_onehot(iDat[c*WIDTH_IN +: WIDTH_IN]);
  end

  if (PIPE == 1) begin : g_e1
    assign nxt_err = err_d;
  end else begin : g_e2
    logic [CHN-1:0] err_q;
    // Error flags ride alongside the stage 0 group payload.
    always_ff @(posedge clk) begin
      if (ld0) err_q <= err_d;
    end
    assign nxt_err = err_q;
  end

  // Output error flags and sticky summary of every delivered error beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_err <= '0;
      err_stk <= 1'b0;
    end else begin
      if (ld_last) out_err <= nxt_err;
      if (vld_out & oRdy & (|out_err)) err_stk <= 1'b1;
    end
  end

  assign oErr    = out_err;
  assign oErrStk = err_stk;
`endif

endmodule

// File: tb/tb_zion_oh2bin_pipe.sv
// tb_zion_oh2bin_pipe
//   Directed bench over four configurations of zion_oh2bin_pipe:
//   A default (PIPE=1, 8->3), B START=2/STEP=3 4->4, C PIPE=2 CHN=2 16->4, D PIPE=2 8->3.
//   oErr/oErrStk checks are active when ZION_OH2BIN_ERRCHK_EN is defined.
module tb_zion_oh2bin_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic       a_ivld, a_irdy, a_ovld, a_ordy, a_ohit;
  logic [7:0] a_idat;
  logic [2:0] a_odat;
  logic       b_ivld, b_irdy, b_ovld, b_ordy, b_ohit;
  logic [3:0] b_idat, b_odat;
  logic        c_ivld, c_irdy, c_ovld, c_ordy;
  logic [31:0] c_idat;
  logic [7:0]  c_odat;
  logic [1:0]  c_ohit;
  logic       d_ivld, d_irdy, d_ovld, d_ordy, d_ohit;
  logic [7:0] d_idat;
  logic [2:0] d_odat;
`ifdef ZION_OH2BIN_ERRCHK_EN
  logic       a_oerr, a_stk, b_oerr, b_stk, c_stk, d_oerr, d_stk;
  logic [1:0] c_oerr;
`endif

  zion_oh2bin_pipe #(.WIDTH_IN(8), .WIDTH_OUT(3), .CHN(1), .START(0), .STEP(1), .PIPE(1), .GRP(4)) u_a (
    .clk(clk), .rst_n(rst_n), .iVld(a_ivld), .iRdy(a_irdy), .iDat(a_idat),
    .oVld(a_ovld), .oRdy(a_ordy), .oDat(a_odat), .oHit(a_ohit)
`ifdef ZION_OH2BIN_ERRCHK_EN
    , .oErr(a_oerr), .oErrStk(a_stk)
`endif
  );

  zion_oh2bin_pipe #(.WIDTH_IN(4), .WIDTH_OUT(4), .CHN(1), .START(2), .STEP(3), .PIPE(1), .GRP(4)) u_b (
    .clk(clk), .rst_n(rst_n), .iVld(b_ivld), .iRdy(b_irdy), .iDat(b_idat),
    .oVld(b_ovld), .oRdy(b_ordy), .oDat(b_odat), .oHit(b_ohit)
`ifdef ZION_OH2BIN_ERRCHK_EN
    , .oErr(b_oerr), .oErrStk(b_stk)
`endif
  );

  zion_oh2bin_pipe #(.WIDTH_IN(16), .WIDTH_OUT(4), .CHN(2), .START(0), .STEP(1), .PIPE(2), .GRP(4)) u_c (
    .clk(clk), .rst_n(rst_n), .iVld(c_ivld), .iRdy(c_irdy), .iDat(c_idat),
    .oVld(c_ovld), .oRdy(c_ordy), .oDat(c_odat), .oHit(c_ohit)
`ifdef ZION_OH2BIN_ERRCHK_EN
    , .oErr(c_oerr), .oErrStk(c_stk)
`endif
  );

  zion_oh2bin_pipe #(.WIDTH_IN(8), .WIDTH_OUT(3), .CHN(1), .START(0), .STEP(1), .PIPE(2), .GRP(4)) u_d (
    .clk(clk), .rst_n(rst_n), .iVld(d_ivld), .iRdy(d_irdy), .iDat(d_idat),
    .oVld(d_ovld), .oRdy(d_ordy), .oDat(d_odat), .oHit(d_ohit)
`ifdef ZION_OH2BIN_ERRCHK_EN
    , .oErr(d_oerr), .oErrStk(d_stk)
`endif
  );

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (a_ovld !== 1'b0) begin errors++; $display("FAIL rst_a_ovld got %b exp 0", a_ovld); end
    checks++; if (a_odat !== 3'd0) begin errors++; $display("FAIL rst_a_odat got %0d exp 0", a_odat); end
    checks++; if (a_ohit !== 1'b0) begin errors++; $display("FAIL rst_a_ohit got %b exp 0", a_ohit); end
    checks++; if (a_irdy !== 1'b1) begin errors++; $display("FAIL rst_a_irdy got %b exp 1", a_irdy); end
    checks++; if (b_odat !== 4'd0) begin errors++; $display("FAIL rst_b_odat got %0d exp 0", b_odat); end
    checks++; if (c_ovld !== 1'b0) begin errors++; $display("FAIL rst_c_ovld got %b exp 0", c_ovld); end
    checks++; if (c_odat !== 8'h00) begin errors++; $display("FAIL rst_c_odat got %h exp 00", c_odat); end
    checks++; if (c_ohit !== 2'b00) begin errors++; $display("FAIL rst_c_ohit got %b exp 00", c_ohit); end
    checks++; if (d_ovld !== 1'b0) begin errors++; $display("FAIL rst_d_ovld got %b exp 0", d_ovld); end
`ifdef ZION_OH2BIN_ERRCHK_EN
    checks++; if (c_oerr !== 2'b00) begin errors++; $display("FAIL rst_c_oerr got %b exp 00", c_oerr); end
    checks++; if (b_stk !== 1'b0) begin errors++; $display("FAIL rst_b_stk got %b exp 0", b_stk); end
`endif
    #10 rst_n = 1'b1;
  endtask

  // Single beats through A with idle gaps: latency 1, priority on multi-hot, all-zero lane.
  task automatic test_basic();
    logic [7:0] vin  [5];
    logic [2:0] vexp [5];
    logic       vhit [5];
`ifdef ZION_OH2BIN_ERRCHK_EN
    logic       verr [5];
    verr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
    vin  = '{8'h10, 8'h01, 8'h80, 8'h64, 8'h00};
    vexp = '{3'd4, 3'd0, 3'd7, 3'd2, 3'd0};
    vhit = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    a_ordy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      a_ivld = 1'b1; a_idat = vin[i];
      #1;
      checks++; if (a_irdy !== 1'b1) begin errors++; $display("FAIL basic_irdy[%0d] got %b exp 1", i, a_irdy); end
      checks++; if (a_ovld !== 1'b0) begin errors++; $display("FAIL basic_ovld_pre[%0d] got %b exp 0", i, a_ovld); end
      step();
      a_ivld = 1'b0; a_idat = 8'hFF;
      #1;
      checks++; if (a_ovld !== 1'b1) begin errors++; $display("FAIL basic_ovld[%0d] got %b exp 1", i, a_ovld); end
      checks++; if (a_odat !== vexp[i]) begin errors++; $display("FAIL basic_odat[%0d] got %0d exp %0d", i, a_odat, vexp[i]); end
      checks++; if (a_ohit !== vhit[i]) begin errors++; $display("FAIL basic_ohit[%0d] got %b exp %b", i, a_ohit, vhit[i]); end
`ifdef ZION_OH2BIN_ERRCHK_EN
      checks++; if (a_oerr !== verr[i]) begin errors++; $display("FAIL basic_oerr[%0d] got %b exp %b", i, a_oerr, verr[i]); end
`endif
      step();
      #1;
      checks++; if (a_ovld !== 1'b0) begin errors++; $display("FAIL basic_ovld_post[%0d] got %b exp 0", i, a_ovld); end
    end
  endtask

  // Continuous stream through A: one beat per cycle, no bubbles.
  task automatic test_back_to_back();
    logic [7:0] vin  [5];
    logic [2:0] vexp [5];
    logic       vhit [5];
    vin  = '{8'h02, 8'h40, 8'h00, 8'h18, 8'h80};
    vexp = '{3'd1, 3'd6, 3'd0, 3'd3, 3'd7};
    vhit = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    a_ordy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      a_ivld = 1'b1; a_idat = vin[i];
      #1;
      checks++; if (a_irdy !== 1'b1) begin errors++; $display("FAIL b2b_irdy[%0d] got %b exp 1", i, a_irdy); end
      if (i > 0) begin
        checks++; if (a_ovld !== 1'b1) begin errors++; $display("FAIL b2b_ovld[%0d] got %b exp 1", i - 1, a_ovld); end
        checks++; if (a_odat !== vexp[i-1]) begin errors++; $display("FAIL b2b_odat[%0d] got %0d exp %0d", i - 1, a_odat, vexp[i-1]); end
        checks++; if (a_ohit !== vhit[i-1]) begin errors++; $display("FAIL b2b_ohit[%0d] got %b exp %b", i - 1, a_ohit, vhit[i-1]); end
      end
    end
    step();
    a_ivld = 1'b0;
    #1;
    checks++; if (a_ovld !== 1'b1) begin errors++; $display("FAIL b2b_ovld[4] got %b exp 1", a_ovld); end
    checks++; if (a_odat !== vexp[4]) begin errors++; $display("FAIL b2b_odat[4] got %0d exp %0d", a_odat, vexp[4]); end
    step();
    #1;
    checks++; if (a_ovld !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", a_ovld); end
  endtask

  // B: START=2, STEP=3; sticky error summary accumulates across delivered beats.
  task automatic test_offset();
    logic [3:0] vin  [5];
    logic [3:0] vexp [5];
    logic       vhit [5];
`ifdef ZION_OH2BIN_ERRCHK_EN
    logic       verr [5];
    logic       stk_exp;
    verr    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    stk_exp = 1'b0;
`endif
    vin  = '{4'b1000, 4'b0001, 4'b0000, 4'b0110, 4'b0100};
    vexp = '{4'd11, 4'd2, 4'd0, 4'd5, 4'd8};
    vhit = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    b_ordy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      b_ivld = 1'b1; b_idat = vin[i];
      step();
      b_ivld = 1'b0;
      #1;
      checks++; if (b_ovld !== 1'b1) begin errors++; $display("FAIL ofs_ovld[%0d] got %b exp 1", i, b_ovld); end
      checks++; if (b_odat !== vexp[i]) begin errors++; $display("FAIL ofs_odat[%0d] got %0d exp %0d", i, b_odat, vexp[i]); end
      checks++; if (b_ohit !== vhit[i]) begin errors++; $display("FAIL ofs_ohit[%0d] got %b exp %b", i, b_ohit, vhit[i]); end
`ifdef ZION_OH2BIN_ERRCHK_EN
      checks++; if (b_oerr !== verr[i]) begin errors++; $display("FAIL ofs_oerr[%0d] got %b exp %b", i, b_oerr, verr[i]); end
      stk_exp = stk_exp | verr[i];
`endif
      step();
      #1;
`ifdef ZION_OH2BIN_ERRCHK_EN
      checks++; if (b_stk !== stk_exp) begin errors++; $display("FAIL ofs_stk[%0d] got %b exp %b", i, b_stk, stk_exp); end
`endif
    end
  endtask

  // C: two lanes, PIPE=2, back-to-back beats; latency 2, lanes independent.
  task automatic test_multichan();
    logic [31:0] vin  [4];
    logic [7:0]  vexp [4];
    logic [1:0]  vhit [4];
`ifdef ZION_OH2BIN_ERRCHK_EN
    logic [1:0]  verr [4];
    verr = '{2'b10, 2'b10, 2'b01, 2'b10};
`endif
    vin  = '{{16'h0006, 16'h0100}, {16'h0000, 16'h8000}, {16'h0800, 16'h0030}, {16'h1010, 16'h0001}};
    vexp = '{8'h18, 8'h0F, 8'hB4, 8'h40};
    vhit = '{2'b11, 2'b01, 2'b11, 2'b11};
    c_ordy = 1'b1;
    for (int cyc = 0; cyc < 7; cyc++) begin
      step();
      c_ivld = (cyc < 4);
      c_idat = (cyc < 4) ? vin[cyc] : 32'hFFFF_FFFF;
      #1;
      checks++; if (c_irdy !== 1'b1) begin errors++; $display("FAIL mc_irdy[%0d] got %b exp 1", cyc, c_irdy); end
      checks++;
      if (c_ovld !== (cyc >= 2 && cyc < 6)) begin
        errors++; $display("FAIL mc_ovld[%0d] got %b exp %b", cyc, c_ovld, (cyc >= 2 && cyc < 6));
      end
      if (cyc >= 2 && cyc < 6) begin
        checks++; if (c_odat !== vexp[cyc-2]) begin errors++; $display("FAIL mc_odat[%0d] got %h exp %h", cyc - 2, c_odat, vexp[cyc-2]); end
        checks++; if (c_ohit !== vhit[cyc-2]) begin errors++; $display("FAIL mc_ohit[%0d] got %b exp %b", cyc - 2, c_ohit, vhit[cyc-2]); end
`ifdef ZION_OH2BIN_ERRCHK_EN
        checks++; if (c_oerr !== verr[cyc-2]) begin errors++; $display("FAIL mc_oerr[%0d] got %b exp %b", cyc - 2, c_oerr, verr[cyc-2]); end
`endif
      end
    end
    c_ivld = 1'b0;
  endtask

  // D: stream indices 0..7 with oRdy low in cycles 3-6; order, stability, iRdy and no loss.
  task automatic test_backpressure();
    int         sent;
    int         rcvd;
    int         occ;
    logic       held_vld;
    logic [2:0] held_dat;
    logic       seen_block;
    logic       fin;
    logic       fout;
    sent = 0; rcvd = 0; occ = 0; held_vld = 1'b0; held_dat = '0; seen_block = 1'b0;
    for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
      step();
      d_ordy = !(cyc >= 3 && cyc <= 6);
      d_ivld = (sent < 8);
      d_idat = 8'(1 << sent);
      #1;
      checks++;
      if (d_irdy !== ((occ < 2) || d_ordy)) begin
        errors++; $display("FAIL bp_irdy[%0d] got %b exp %b", cyc, d_irdy, ((occ < 2) || d_ordy));
      end
      if (d_irdy === 1'b0) seen_block = 1'b1;
      if (held_vld) begin
        checks++; if (d_ovld !== 1'b1) begin errors++; $display("FAIL bp_hold_vld[%0d] got %b exp 1", cyc, d_ovld); end
        checks++; if (d_odat !== held_dat) begin errors++; $display("FAIL bp_hold_dat[%0d] got %0d exp %0d", cyc, d_odat, held_dat); end
      end
      fout = d_ovld & d_ordy;
      if (fout) begin
        checks++; if (d_odat !== 3'(rcvd)) begin errors++; $display("FAIL bp_order[%0d] got %0d exp %0d", rcvd, d_odat, rcvd); end
        checks++; if (d_ohit !== 1'b1) begin errors++; $display("FAIL bp_ohit[%0d] got %b exp 1", rcvd, d_ohit); end
        rcvd++;
      end
      fin = d_ivld & d_irdy;
      if (fin) sent++;
      occ = occ + int'(fin) - int'(fout);
      held_vld = d_ovld & ~d_ordy;
      held_dat = d_odat;
    end
    d_ivld = 1'b0;
    d_ordy = 1'b1;
    checks++; if (rcvd != 8) begin errors++; $display("FAIL bp_count got %0d exp 8", rcvd); end
    checks++; if (seen_block !== 1'b1) begin errors++; $display("FAIL bp_blocked got %b exp 1", seen_block); end
  endtask

  // Reset with beats in flight, then a fresh beat behaves as from idle.
  task automatic test_reset_midstream();
    step();
    d_ordy = 1'b0; d_ivld = 1'b1; d_idat = 8'h02;
    b_ordy = 1'b1; b_ivld = 1'b1; b_idat = 4'b0000;
    step();
    d_idat = 8'h08;
    b_ivld = 1'b0;
    step();
    d_ivld = 1'b0;
    #1;
    checks++; if (d_ovld !== 1'b1) begin errors++; $display("FAIL mid_pre_ovld got %b exp 1", d_ovld); end
    checks++; if (d_irdy !== 1'b0) begin errors++; $display("FAIL mid_pre_irdy got %b exp 0", d_irdy); end
`ifdef ZION_OH2BIN_ERRCHK_EN
    checks++; if (b_stk !== 1'b1) begin errors++; $display("FAIL mid_pre_stk got %b exp 1", b_stk); end
`endif
    #2 rst_n = 1'b0;
    #1;
    checks++; if (d_ovld !== 1'b0) begin errors++; $display("FAIL mid_rst_ovld got %b exp 0", d_ovld); end
    checks++; if (d_odat !== 3'd0) begin errors++; $display("FAIL mid_rst_odat got %0d exp 0", d_odat); end
    checks++; if (d_ohit !== 1'b0) begin errors++; $display("FAIL mid_rst_ohit got %b exp 0", d_ohit); end
    checks++; if (d_irdy !== 1'b1) begin errors++; $display("FAIL mid_rst_irdy got %b exp 1", d_irdy); end
`ifdef ZION_OH2BIN_ERRCHK_EN
    checks++; if (b_stk !== 1'b0) begin errors++; $display("FAIL mid_rst_stk got %b exp 0", b_stk); end
`endif
    #8 rst_n = 1'b1;
    d_ordy = 1'b1;
    step();
    d_ivld = 1'b1; d_idat = 8'h01;
    b_ivld = 1'b1; b_idat = 4'b0001;
    #1;
    checks++; if (d_irdy !== 1'b1) begin errors++; $display("FAIL mid_post_irdy got %b exp 1", d_irdy); end
    step();
    d_ivld = 1'b0; b_ivld = 1'b0;
    #1;
    checks++; if (b_ovld !== 1'b1) begin errors++; $display("FAIL mid_post_b_ovld got %b exp 1", b_ovld); end
    checks++; if (b_odat !== 4'd2) begin errors++; $display("FAIL mid_post_b_odat got %0d exp 2", b_odat); end
    checks++; if (d_ovld !== 1'b0) begin errors++; $display("FAIL mid_post_d_lat1 got %b exp 0", d_ovld); end
    step();
    #1;
    checks++; if (d_ovld !== 1'b1) begin errors++; $display("FAIL mid_post_d_ovld got %b exp 1", d_ovld); end
    checks++; if (d_odat !== 3'd0) begin errors++; $display("FAIL mid_post_d_odat got %0d exp 0", d_odat); end
    checks++; if (d_ohit !== 1'b1) begin errors++; $display("FAIL mid_post_d_ohit got %b exp 1", d_ohit); end
  endtask

  initial begin
    a_ivld = 1'b0; a_idat = '0; a_ordy = 1'b1;
    b_ivld = 1'b0; b_idat = '0; b_ordy = 1'b1;
    c_ivld = 1'b0; c_idat = '0; c_ordy = 1'b1;
    d_ivld = 1'b0; d_idat = '0; d_ordy = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_offset();
    test_multichan();
    test_backpressure();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so a stuck handshake still terminates the run.
  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
